// File: rtl/peripheral_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bit positions
// within the peripheral command/status word and the transmitter FSM states.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
package peripheral_pkg;

  localparam int PERIPH_DATA_MSB = 7;
  localparam int PERIPH_REQ_BIT  = 8;
  localparam int PERIPH_BUSY_BIT = 9;
  localparam int PERIPH_DONE_BIT = 10;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;
`endif

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/peripheral_uart_tx_baud_tick.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last count with a
// one-cycle tick. The owner reloads it through restart whenever a bit starts,
// so it never free-runs across bit boundaries.
module baud_tick #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  // Count up each cycle; reload to zero on restart or reset.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/peripheral_uart_tx.sv
// Memory-mapped UART transmitter. Reads a command word (data byte + REQ) from
// the memory's peripheral word and returns a status word that the memory
// writes back every clock: REQ is cleared in the accept cycle, BUSY tracks an
// active frame and DONE is sticky until the next accept.
// Optional feature macro: UART_TX_PARITY_EN (8E1 instead of 8N1).
module peripheral_uart_tx
  import peripheral_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] peripheral_bus,
  output logic [31:0] wb_peripheral_bus,
  output logic        uart_tx
);

  uart_state_e state_reg;
  logic [7:0]  data_reg;
  logic [2:0]  bit_idx_reg;
  logic        tx_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:PERIPH_DONE_BIT+1] pass_hi_reg;
  logic [PERIPH_REQ_BIT:0]     pass_lo_reg;

  logic accept;
  logic tick;
  logic restart;

  assign accept  = (state_reg == ST_IDLE) && peripheral_bus[PERIPH_REQ_BIT];
  // Timer held at zero while idle so the start bit gets a full period.
  assign restart = (state_reg == ST_IDLE) || tick;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Register pass-through fields; REQ is dropped in the accept cycle only.
  always_ff @(posedge clock) begin
    if (reset) begin
      pass_hi_reg <= '0;
      pass_lo_reg <= '0;
    end else begin
      pass_hi_reg <= peripheral_bus[31:PERIPH_DONE_BIT+1];
      pass_lo_reg <= {peripheral_bus[PERIPH_REQ_BIT] & ~accept,
                      peripheral_bus[PERIPH_DATA_MSB:0]};
    end
  end

  // Transmit FSM with registered line, busy and done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      data_reg    <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (accept) begin
            data_reg    <= peripheral_bus[PERIPH_DATA_MSB:0];
            bit_idx_reg <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            tx_reg      <= 1'b0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_reg      <= data_reg[0];
            bit_idx_reg <= '0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= even_parity(data_reg);
              state_reg <= ST_PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
`endif
            end else begin
              tx_reg      <= data_reg[bit_idx_reg + 3'd1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx_reg    <= 1'b1;
            state_reg <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_tx = tx_reg;
  assign wb_peripheral_bus = {pass_hi_reg, done_reg, busy_reg, pass_lo_reg};

endmodule
